// File: rtl/via_bus_sequencer_if.sv
// Requester and VIA-side signal bundle for via_bus_sequencer.
// The sequencer uses the slave view; the CPU/host/VIA side uses master.
interface via_bus_sequencer_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic       host_req;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       host_ack;
  logic [3:0] via_addr;
  logic       via_wen;
  logic       via_ren;
  logic [7:0] via_din;
  logic [7:0] via_dout;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    input  via_addr, via_wen, via_ren, via_din,
    output via_dout
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    output via_addr, via_wen, via_ren, via_din,
    input  via_dout
  );
endinterface

// File: rtl/via_bus_sequencer.sv
// 6522 E-clock phase generator and CPU/host arbiter that runs one VIA
// register access per E period, spanning the whole E-high phase.
module via_bus_sequencer #(
  parameter int E_DIV         = 10,
  parameter int E_HIGH        = 4,
  parameter int HOST_MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clk_en,
  output logic              e_clk,
  output logic              via_rising,
  output logic              via_falling,
  via_bus_sequencer_if.slave bus
);
  localparam int PW = $clog2(E_DIV);
  localparam int LW = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(E_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(E_DIV - E_HIGH - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(E_DIV - E_HIGH);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, ACTIVE, DONE} state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [PW-1:0] ph_r;
  logic [PW-1:0] ph_next_s;
  logic          e_clk_r;
  logic          owner_r;
  logic          cur_we_r;
  logic [LW-1:0] loss_r;
  logic          grant_s;
  logic          host_wins_s;
  logic          owner_req_s;
  logic [3:0]    via_addr_r;
  logic [7:0]    via_din_r;
  logic [7:0]    cpu_rdata_r;
  logic [7:0]    host_rdata_r;
  logic          cpu_ack_r;
  logic          host_ack_r;

  assign ph_next_s   = (ph_r == PH_LAST) ? '0 : ph_r + PW'(1);
  assign e_clk       = e_clk_r;
  assign via_rising  = clk_en && !reset && (ph_r == PH_RISE);
  assign via_falling = clk_en && !reset && (ph_r == PH_LAST);

  // Phase counter; e_clk follows the phase it is entering so it always equals (ph >= high start)
  always_ff @(posedge clock) begin
    if (reset) begin
      ph_r    <= '0;
      e_clk_r <= 1'b0;
    end else if (clk_en) begin
      ph_r    <= ph_next_s;
      e_clk_r <= (ph_next_s >= PH_HIGH);
    end
  end

  // Arbitration decode and next-state logic
  always_comb begin
    host_wins_s  = bus.host_req && (!bus.cpu_req || (loss_r == LW'(HOST_MAX_WAIT)));
    grant_s      = (state_r == IDLE) && (bus.cpu_req || bus.host_req);
    owner_req_s  = owner_r ? bus.host_req : bus.cpu_req;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_next_s = WAIT_RISE;
        else         state_next_s = IDLE;
      end
      WAIT_RISE: begin
        // An owner that gives up before the E-high phase gets no VIA cycle at all
        if (!owner_req_s)    state_next_s = IDLE;
        else if (via_rising) state_next_s = ACTIVE;
        else                 state_next_s = WAIT_RISE;
      end
      ACTIVE: begin
        if (via_falling) state_next_s = DONE;
        else             state_next_s = ACTIVE;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Grant latching, loss counter, read capture and ack pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r      <= 1'b0;
      cur_we_r     <= 1'b0;
      loss_r       <= '0;
      via_addr_r   <= 4'h0;
      via_din_r    <= 8'h00;
      cpu_rdata_r  <= 8'h00;
      host_rdata_r <= 8'h00;
      cpu_ack_r    <= 1'b0;
      host_ack_r   <= 1'b0;
    end else begin
      cpu_ack_r  <= 1'b0;
      host_ack_r <= 1'b0;
      if (grant_s) begin
        owner_r    <= host_wins_s;
        cur_we_r   <= host_wins_s ? bus.host_we    : bus.cpu_we;
        via_addr_r <= host_wins_s ? bus.host_addr  : bus.cpu_addr;
        via_din_r  <= host_wins_s ? bus.host_wdata : bus.cpu_wdata;
        if (host_wins_s)       loss_r <= '0;
        else if (bus.host_req) loss_r <= loss_r + LW'(1);
      end
      if ((state_r == ACTIVE) && via_falling && !cur_we_r) begin
        if (owner_r) host_rdata_r <= bus.via_dout;
        else         cpu_rdata_r  <= bus.via_dout;
      end
      if (state_r == DONE) begin
        if (owner_r) host_ack_r <= 1'b1;
        else         cpu_ack_r  <= 1'b1;
      end
    end
  end

  assign bus.via_wen    = (state_r == ACTIVE) && cur_we_r;
  assign bus.via_ren    = (state_r == ACTIVE) && !cur_we_r;
  assign bus.via_addr   = via_addr_r;
  assign bus.via_din    = via_din_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.host_rdata = host_rdata_r;
  assign bus.cpu_ack    = cpu_ack_r;
  assign bus.host_ack   = host_ack_r;
endmodule

// File: doc/via_bus_sequencer.md
Name: via_bus_sequencer

Overview:
- Generates the 6522 E-clock phase strobes (rising/falling) from the system clock.
- Arbitrates VIA register access between two requesters: the CPU (68000 VPA-style synchronous cycle) and a host/OSD port.
- Sequences each access so that ren/wen, addr and data_in are stable across one full E-high phase, and captures read data at the falling strobe.
- Sits between the CPU bus decode and the VIA instance.

Parameters:
- E_DIV, 10, system-clock enable ticks per E period (legal 4..16).
- E_HIGH, 4, ticks per period with e_clk high (1..E_DIV-1).
- HOST_MAX_WAIT, 3, consecutive host arbitration losses after which the host wins the next arbitration.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clk_en  in  1  tick enable; the phase counter advances only when clk_en=1.
- e_clk  out  1  E clock level.
- via_rising  out  1  one-clock pulse at the E low→high transition.
- via_falling  out  1  one-clock pulse at the E high→low transition.
- cpu_req  in  1  level request, held until cpu_ack.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  4  VIA register.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data, valid with cpu_ack.
- cpu_ack  out  1  one-clock completion pulse.
- host_req, host_we, host_addr[3:0], host_wdata[7:0], host_rdata[7:0], host_ack: same semantics as the cpu_* signals.
- via_addr  out  4  to VIA addr.
- via_wen  out  1  to VIA wen.
- via_ren  out  1  to VIA ren.
- via_din  out  8  to VIA data_in.
- via_dout  in  8  from VIA data_out.

Behaviour:
- Phase counter ph runs 0..E_DIV-1 and increments on clk_en, wrapping E_DIV-1→0.
  - e_clk = (ph >= E_DIV-E_HIGH), registered.
  - via_rising = 1 for exactly the clock in which clk_en=1 and ph = E_DIV-E_HIGH-1, i.e. ph is about to enter the high region.
  - via_falling = 1 for exactly the clock in which clk_en=1 and ph = E_DIV-1.
  - Strobes never assert when clk_en=0; the counter freezes.
- Reset values:
  - ph=0, e_clk=0, both strobes 0, FSM=IDLE.
  - via_wen, via_ren, cpu_ack, host_ack = 0.
  - via_addr=0, via_din=0, cpu_rdata=host_rdata=0, host loss counter=0.
- FSM states: IDLE, WAIT_RISE, ACTIVE, DONE.
  - IDLE:
    - If any req is present, arbitrate, latch the winner's we/addr/wdata into via_addr/via_din and a cur_we register, then go to WAIT_RISE.
    - Latched values hold until return to IDLE.
  - WAIT_RISE:
    - On the via_rising clock, go to ACTIVE.
    - If the owner's req drops while in WAIT_RISE: return to IDLE with no VIA cycle and no ack.
  - ACTIVE:
    - via_wen=cur_we and via_ren=!cur_we, asserted combinationally from the state.
    - Asserted starting the clock after via_rising, through and including the via_falling clock.
    - On the via_falling clock: latch via_dout into the owner's rdata (read cycles only), then go to DONE.
    - A req drop during ACTIVE does not abort: the cycle completes and ack is still pulsed.
  - DONE:
    - Pulse the owner's ack for one clock, then go to IDLE.
    - A new arbitration may occur on the following clock.
- Arbitration (IDLE only):
  - The CPU wins by default.
  - The host wins if only the host requests, or if the loss counter equals HOST_MAX_WAIT.
  - The loss counter increments when both request and the CPU wins; it clears when the host wins.
  - Ack goes only to the owner; the loser's req stays pending.
- Latency: ack occurs 2 clocks after the falling strobe of the first E period whose rising strobe follows the grant. A grant in the same clock as via_rising waits a full E period.
- Only one VIA cycle per E period; back-to-back requests use consecutive periods when clk_en is continuous and E_HIGH < E_DIV-2.
- Reset mid-operation: the FSM aborts immediately, no ack, strobes and ren/wen drop the next clock.

Test Plan:
- Reset, clk_en=1 constant, E_DIV=10, E_HIGH=4: e_clk high 4 / low 6 clocks; via_rising and via_falling each exactly 1 clock per 10; the falling strobe coincides with the last e_clk high clock.
- CPU write addr=4'hB, wdata=8'h40: via_wen high for exactly 4 clocks ending on via_falling; via_addr=B and via_din=40 stable throughout; cpu_ack single pulse; via_ren never high.
- CPU read addr=4'hE with via_dout forced to 8'hC2 at the falling clock: cpu_rdata=C2 with cpu_ack; via_ren covers the falling strobe.
- cpu_req and host_req held continuously, HOST_MAX_WAIT=3: grant order CPU,CPU,CPU,HOST,CPU,CPU,CPU,HOST; no two grants in one E period.
- Host request dropped during WAIT_RISE: no via_ren/via_wen, no host_ack, FSM back in IDLE; a CPU request then completes normally.
- Reset asserted mid-ACTIVE, and clk_en=0 for 7 clocks mid-cycle: reset clears all outputs within 1 clock; with clk_en low, ph and strobes freeze, ren/wen stay asserted, and the cycle completes after clk_en resumes.
